i2c_master_burst_ctrl: RTL
==========================

Name: i2c_master_burst_ctrl

Overview:
Parametrised successor to the single-byte I2C command controller. Executes a complete burst from one command strobe: optional (repeated) START, header/data write bytes or read bytes, per-byte ACK handling, automatic master NACK on the last read byte, and optional STOP.
- Owns an internal BYTE_W shift register.
- Streams data through valid/ready handshakes, so the host no longer re-arms the block for every byte.
- Sits between the register/host interface and the existing bit controller; bit-controller command codes come from the existing I2C define set.

Parameters:
BYTE_W, 8, bits per transferred word (shift length; I2C uses 8)
LEN_W, 4, width of burst length field; max burst 2^LEN_W words

Ports:
Clk  in  1  system clock
Rst_n  in  1  asynchronous active-low reset
Go  in  1  one-cycle command strobe; sampled only in IDLE
Start  in  1  generate START/repeated START before the burst
Stop  in  1  generate STOP after the burst
Read  in  1  1: read burst; 0: write burst
Len  in  LEN_W  burst length minus one (0 means 1 word)
Tx_data  in  BYTE_W  next write word
Tx_valid  in  1  Tx_data valid
Tx_ready  out  1  word accepted this cycle
Rx_data  out  BYTE_W  received word
Rx_valid  out  1  one-cycle pulse, Rx_data valid
Rx_ack  out  1  last slave ACK bit (0 = ACK)
Busy  out  1  burst in progress
I2C_done  out  1  one-cycle pulse at burst end (normal or aborted)
Nack_err  out  1  burst ended early on slave NACK; held until next Go
I2C_al  in  1  arbitration lost from bit controller
Al_err  out  1  burst aborted on I2C_al; held until next Go
Bit_cmd  out  4  command to bit controller
Bit_txd  out  1  serial bit to bit controller
Bit_ack  in  1  bit controller command complete
Bit_rxd  in  1  bit received from SDA

Behaviour:
- Reset values: Bit_cmd=NOP, Bit_txd=0, Tx_ready=0, Rx_data=0, Rx_valid=0, Rx_ack=1, Busy=0, I2C_done=0, Nack_err=0, Al_err=0, state=IDLE, counters=0.
- All outputs are registered. Bit_cmd changes in the same edge as the state transition that requires it and holds until the next transition.
- Go in IDLE:
  - Latch Start, Stop, Read and Len.
  - Clear Nack_err and Al_err; set Busy.
  - Go while Busy is ignored.
- States:
  - IDLE: on Go, go to START if Start=1; else LOAD.
  - START: Bit_cmd=START; on Bit_ack, go to LOAD.
  - LOAD:
    - Write: wait for Tx_valid (Bit_cmd=NOP during stall). Tx_ready pulses one cycle, the shift register loads Tx_data, and the FSM goes to WRITE with Bit_cmd=WRITE and Bit_txd=MSB.
    - Read: go directly to READ with Bit_cmd=READ.
    - Bit counter loads BYTE_W-1.
  - WRITE: on each Bit_ack, shift left and present the next MSB. After BYTE_W acks, go to WACK with Bit_cmd=READ.
  - WACK: on Bit_ack, Rx_ack<=Bit_rxd.
    - Bit_rxd=1: set Nack_err, go to STOP if latched Stop, else FIN.
    - Last word: go to STOP if Stop, else FIN.
    - Otherwise: decrement word counter, go to LOAD.
  - READ: on each Bit_ack, shift in Bit_rxd at LSB. After BYTE_W acks:
    - Rx_data and Rx_valid pulse on the same edge.
    - Go to RACK with Bit_cmd=WRITE.
    - Bit_txd=0 for non-last words, 1 (NACK) for the last word.
  - RACK: on Bit_ack, go to LOAD if words remain; else STOP if Stop, else FIN.
  - STOP: Bit_cmd=STOP; on Bit_ack, go to FIN.
  - FIN: Bit_cmd=NOP, I2C_done=1 for one cycle, Busy=0, go to IDLE.
- Word counter: loads Len on Go, decrements after each word's ACK phase. The last word is counter==0; no wrap.
- Len=2^LEN_W-1 transfers 2^LEN_W words.
- I2C_al=1 in any non-IDLE state, with priority over Bit_ack on the same cycle:
  - Next edge: Bit_cmd=NOP, Al_err=1, I2C_done pulse, Busy=0, state=IDLE.
  - No STOP is issued.
- Write underflow: Tx_valid low in LOAD stalls indefinitely; SCL is held by the bit controller idle, not a protocol error.
- Rx has no back-pressure; the host must accept Rx_valid pulses.
- Asynchronous reset mid-burst returns everything to reset values immediately; no STOP is generated.

Test Plan:
- Write, Start=1 Stop=1 Len=1, Tx 0xA0 then 0x5C, slave ACKs all -> START, 18 WRITE/READ cmds, bit sequence 10100000/0/01011100/0, STOP, one I2C_done, Nack_err=0, Rx_ack=0.
- Read, Start=1 Stop=1 Len=2, slave drives 0x12,0x34,0x56 -> three Rx_valid pulses with those values; master ack bits 0,0,1; STOP; I2C_done.
- Write Len=3 with slave NACK (Bit_rxd=1) in the second WACK -> only 2 Tx_ready pulses, Nack_err=1, Rx_ack=1, STOP issued, I2C_done.
- Write, Tx_valid withheld 20 cycles in LOAD -> Bit_cmd=NOP, Tx_ready=0 for 20 cycles; burst resumes on Tx_valid and completes correctly.
- I2C_al asserted during bit 4 of a read, with Bit_ack on the same cycle -> next edge Bit_cmd=NOP, Al_err=1, I2C_done pulse, no Rx_valid, no STOP.
- Rst_n low mid-WRITE, then Go with Start=0 Stop=0 Len=0 -> all outputs at reset values; new burst issues no START/STOP, writes 1 word, I2C_done.

Source files
------------

// File: rtl/i2c_master_burst_ctrl_if.sv
// Host and bit-controller signal bundle for the I2C burst controller.
// The master modport is the burst controller's view; the slave modport is
// the view of everything around it (host side and bit controller).
interface i2c_master_burst_ctrl_if #(
    parameter int BYTE_W = 8,
    parameter int LEN_W  = 4
);
    logic              Go;
    logic              Start;
    logic              Stop;
    logic              Read;
    logic [LEN_W-1:0]  Len;
    logic [BYTE_W-1:0] Tx_data;
    logic              Tx_valid;
    logic              Tx_ready;
    logic [BYTE_W-1:0] Rx_data;
    logic              Rx_valid;
    logic              Rx_ack;
    logic              Busy;
    logic              I2C_done;
    logic              Nack_err;
    logic              I2C_al;
    logic              Al_err;
    logic [3:0]        Bit_cmd;
    logic              Bit_txd;
    logic              Bit_ack;
    logic              Bit_rxd;

    modport master (
        input  Go, Start, Stop, Read, Len, Tx_data, Tx_valid,
        input  I2C_al, Bit_ack, Bit_rxd,
        output Tx_ready, Rx_data, Rx_valid, Rx_ack, Busy, I2C_done,
        output Nack_err, Al_err, Bit_cmd, Bit_txd
    );

    modport slave (
        output Go, Start, Stop, Read, Len, Tx_data, Tx_valid,
        output I2C_al, Bit_ack, Bit_rxd,
        input  Tx_ready, Rx_data, Rx_valid, Rx_ack, Busy, I2C_done,
        input  Nack_err, Al_err, Bit_cmd, Bit_txd
    );
endinterface

// File: rtl/i2c_master_burst_ctrl.sv
// I2C burst controller: runs a whole START / N words / STOP sequence from a
// single Go strobe, feeding the bit controller one bit command at a time.
// Write words stream in over Tx valid/ready, read words stream out as
// Rx_valid pulses, and the master NACKs the final read word on its own.
module i2c_master_burst_ctrl #(
    parameter int BYTE_W = 8,
    parameter int LEN_W  = 4
) (
    input  logic                   Clk,
    input  logic                   Rst_n,
    i2c_master_burst_ctrl_if.master bus
);
    // Bit-controller command codes from the existing I2C define set
    localparam logic [3:0] CMD_NOP   = 4'b0000;
    localparam logic [3:0] CMD_START = 4'b0001;
    localparam logic [3:0] CMD_STOP  = 4'b0010;
    localparam logic [3:0] CMD_WRITE = 4'b0100;
    localparam logic [3:0] CMD_READ  = 4'b1000;

    localparam int              CNT_W    = (BYTE_W > 1) ? $clog2(BYTE_W) : 1;
    localparam logic [CNT_W-1:0] BIT_LAST = CNT_W'(BYTE_W - 1);

    typedef enum logic [3:0] {
        ST_IDLE, ST_START, ST_LOAD, ST_WRITE, ST_WACK,
        ST_READ, ST_RACK, ST_STOP, ST_FIN
    } state_t;

    state_t             state_q, state_d;
    logic [3:0]         bit_cmd_q, bit_cmd_d;
    logic               bit_txd_q, bit_txd_d;
    logic               tx_ready_q, tx_ready_d;
    logic [BYTE_W-1:0]  rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               rx_ack_q, rx_ack_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic               nack_err_q, nack_err_d;
    logic               al_err_q, al_err_d;
    logic [CNT_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [LEN_W-1:0]   word_cnt_q, word_cnt_d;
    logic               stop_q, stop_d;
    logic               read_q, read_d;
    logic [BYTE_W-1:0]  sreg_q, sreg_d;
    logic               end_burst;

    // Control state and registered outputs; reset returns to idle at once
    always_ff @(posedge Clk or negedge Rst_n) begin
        if (!Rst_n) begin
            state_q    <= ST_IDLE;
            bit_cmd_q  <= CMD_NOP;
            bit_txd_q  <= 1'b0;
            tx_ready_q <= 1'b0;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            rx_ack_q   <= 1'b1;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            nack_err_q <= 1'b0;
            al_err_q   <= 1'b0;
            bit_cnt_q  <= '0;
            word_cnt_q <= '0;
            stop_q     <= 1'b0;
            read_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            bit_cmd_q  <= bit_cmd_d;
            bit_txd_q  <= bit_txd_d;
            tx_ready_q <= tx_ready_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            rx_ack_q   <= rx_ack_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            nack_err_q <= nack_err_d;
            al_err_q   <= al_err_d;
            bit_cnt_q  <= bit_cnt_d;
            word_cnt_q <= word_cnt_d;
            stop_q     <= stop_d;
            read_q     <= read_d;
        end
    end

    // Shift register is pure datapath; its contents are don't-care in idle
    always_ff @(posedge Clk) begin
        sreg_q <= sreg_d;
    end

    // Next-state and next-output decode; arbitration loss overrides everything
    always_comb begin
        state_d    = state_q;
        bit_cmd_d  = bit_cmd_q;
        bit_txd_d  = bit_txd_q;
        tx_ready_d = 1'b0;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        rx_ack_d   = rx_ack_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        nack_err_d = nack_err_q;
        al_err_d   = al_err_q;
        bit_cnt_d  = bit_cnt_q;
        word_cnt_d = word_cnt_q;
        stop_d     = stop_q;
        read_d     = read_q;
        sreg_d     = sreg_q;
        end_burst  = 1'b0;

        if (bus.I2C_al && (state_q != ST_IDLE)) begin
            // Bus is lost: drop straight to idle without issuing STOP
            state_d   = ST_IDLE;
            bit_cmd_d = CMD_NOP;
            al_err_d  = 1'b1;
            done_d    = 1'b1;
            busy_d    = 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (bus.Go) begin
                        stop_d     = bus.Stop;
                        read_d     = bus.Read;
                        word_cnt_d = bus.Len;
                        nack_err_d = 1'b0;
                        al_err_d   = 1'b0;
                        busy_d     = 1'b1;
                        if (bus.Start) begin
                            state_d   = ST_START;
                            bit_cmd_d = CMD_START;
                        end else begin
                            state_d   = ST_LOAD;
                            bit_cmd_d = CMD_NOP;
                        end
                    end
                end
                ST_START: begin
                    if (bus.Bit_ack) begin
                        state_d   = ST_LOAD;
                        bit_cmd_d = CMD_NOP;
                    end
                end
                ST_LOAD: begin
                    if (read_q) begin
                        state_d   = ST_READ;
                        bit_cmd_d = CMD_READ;
                        bit_cnt_d = BIT_LAST;
                    end else if (bus.Tx_valid) begin
                        // Stalling here with NOP is the normal underflow case
                        tx_ready_d = 1'b1;
                        sreg_d     = bus.Tx_data;
                        bit_txd_d  = bus.Tx_data[BYTE_W-1];
                        bit_cmd_d  = CMD_WRITE;
                        bit_cnt_d  = BIT_LAST;
                        state_d    = ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    if (bus.Bit_ack) begin
                        if (bit_cnt_q == '0) begin
                            state_d   = ST_WACK;
                            bit_cmd_d = CMD_READ;
                        end else begin
                            sreg_d    = sreg_q << 1;
                            bit_txd_d = sreg_q[BYTE_W-2];
                            bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_WACK: begin
                    if (bus.Bit_ack) begin
                        rx_ack_d = bus.Bit_rxd;
                        if (bus.Bit_rxd) begin
                            nack_err_d = 1'b1;
                            end_burst  = 1'b1;
                        end else if (word_cnt_q == '0) begin
                            end_burst = 1'b1;
                        end else begin
                            word_cnt_d = word_cnt_q - LEN_W'(1);
                            state_d    = ST_LOAD;
                            bit_cmd_d  = CMD_NOP;
                        end
                    end
                end
                ST_READ: begin
                    if (bus.Bit_ack) begin
                        sreg_d = {sreg_q[BYTE_W-2:0], bus.Bit_rxd};
                        if (bit_cnt_q == '0) begin
                            // Master NACKs the final word so the slave releases SDA
                            rx_data_d  = {sreg_q[BYTE_W-2:0], bus.Bit_rxd};
                            rx_valid_d = 1'b1;
                            state_d    = ST_RACK;
                            bit_cmd_d  = CMD_WRITE;
                            bit_txd_d  = (word_cnt_q == '0);
                        end else begin
                            bit_cnt_d = bit_cnt_q - CNT_W'(1);
                        end
                    end
                end
                ST_RACK: begin
                    if (bus.Bit_ack) begin
                        if (word_cnt_q != '0) begin
                            word_cnt_d = word_cnt_q - LEN_W'(1);
                            state_d    = ST_LOAD;
                            bit_cmd_d  = CMD_NOP;
                        end else begin
                            end_burst = 1'b1;
                        end
                    end
                end
                ST_STOP: begin
                    if (bus.Bit_ack) begin
                        state_d   = ST_FIN;
                        bit_cmd_d = CMD_NOP;
                        done_d    = 1'b1;
                        busy_d    = 1'b0;
                    end
                end
                ST_FIN: begin
                    state_d = ST_IDLE;
                end
                default: begin
                    state_d   = ST_IDLE;
                    bit_cmd_d = CMD_NOP;
                end
            endcase

            // Shared exit path once the last (or NACKed) word is finished
            if (end_burst) begin
                if (stop_q) begin
                    state_d   = ST_STOP;
                    bit_cmd_d = CMD_STOP;
                end else begin
                    state_d   = ST_FIN;
                    bit_cmd_d = CMD_NOP;
                    done_d    = 1'b1;
                    busy_d    = 1'b0;
                end
            end
        end
    end

    assign bus.Bit_cmd  = bit_cmd_q;
    assign bus.Bit_txd  = bit_txd_q;
    assign bus.Tx_ready = tx_ready_q;
    assign bus.Rx_data  = rx_data_q;
    assign bus.Rx_valid = rx_valid_q;
    assign bus.Rx_ack   = rx_ack_q;
    assign bus.Busy     = busy_q;
    assign bus.I2C_done = done_q;
    assign bus.Nack_err = nack_err_q;
    assign bus.Al_err   = al_err_q;
endmodule
